// File: rtl/eth_fcs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_fcs_pkg
// Description : Shared constants, state encoding and helpers for the Ethernet
//               FCS append stage and the receive-side checker.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_fcs_pkg;

  // Reflected CRC-32 polynomial (normal form 0x04C11DB7)
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  // CRC register seed at the start of every frame
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  // Register value left after running a frame plus its FCS through the CRC
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  // Minimum covered byte count (destination address through payload)
  localparam int DEFAULT_MIN_LEN = 60;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SKIP  = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAD   = 3'd3,
    ST_FCS   = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  // FCS byte idx (0 = first on the wire) from the running CRC register.
  // The FCS is the complemented register sent low byte first.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc,
                                          input logic [1:0]  idx);
    logic [31:0] w_fcs;
    w_fcs = ~crc;
    case (idx)
      2'd0:    fcs_byte = w_fcs[7:0];
      2'd1:    fcs_byte = w_fcs[15:8];
      2'd2:    fcs_byte = w_fcs[23:16];
      default: fcs_byte = w_fcs[31:24];
    endcase
  endfunction

endpackage : eth_fcs_pkg
`default_nettype wire

// File: rtl/eth_fcs_append_crc32_byte_step.sv
`default_nettype none
// ============================================================================
// Module      : crc32_byte_step
// Description : Combinational CRC-32 advance by one byte (reflected algorithm,
//               byte consumed LSB first). No init or final inversion here.
// Revision    : 1.0 - initial release
// ============================================================================
module crc32_byte_step
  import eth_fcs_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [31:0] crc_out
);

  logic [31:0] w_crc;
  logic        w_fb;

  // Eight serial LFSR shifts unrolled into one combinational step
  always_comb begin
    w_crc = crc_in;
    w_fb  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_fb  = w_crc[0] ^ byte_in[i];
      w_crc = (w_crc >> 1) ^ (w_fb ? CRC_POLY_REFL : 32'h0000_0000);
    end
    crc_out = w_crc;
  end

endmodule : crc32_byte_step
`default_nettype wire

// File: rtl/eth_fcs_append.sv
`default_nettype none
// ============================================================================
// Module      : eth_fcs_append
// Description : Passes a strobed byte stream through with one cycle of
//               latency, computes the Ethernet FCS over the covered bytes and
//               appends the 4 FCS bytes directly after the last input byte.
//               Optional macro ETH_MIN_PAD_EN: zero-pad short frames up to
//               MIN_LEN covered bytes before the FCS (pad is CRC-covered).
// Revision    : 1.0 - initial release
// ============================================================================
module eth_fcs_append
  import eth_fcs_pkg::*;
#(
  parameter int PRE_SKIP = 8,
  parameter int MIN_LEN  = DEFAULT_MIN_LEN
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] idata,
  input  logic       istrobe,
  output logic [7:0] odata,
  output logic       ostrobe,
  output logic       ofcs,
  output logic       busy,
  output logic       frame_err
);

  // Skip counter holds 1..PRE_SKIP-1 while in SKIP
  localparam int c_SKIP_W = (PRE_SKIP > 1) ? $clog2(PRE_SKIP) : 1;
  localparam logic [c_SKIP_W-1:0] c_SKIP_ONE  = c_SKIP_W'(1);
  localparam logic [c_SKIP_W-1:0] c_SKIP_LAST = c_SKIP_W'(PRE_SKIP - 1);
  localparam logic [10:0]         c_CNT_MAX   = 11'h7FF;
`ifdef ETH_MIN_PAD_EN
  localparam logic [10:0]         c_MIN_LEN   = 11'(MIN_LEN);
`endif

  state_t              r_state;
  logic [31:0]         r_crc;
  logic [10:0]         r_count;
  logic [c_SKIP_W-1:0] r_skip_cnt;
  logic [1:0]          r_fcs_idx;
  logic                r_viol;     // violation already flagged this frame
  logic                r_started;  // first clock after reset has passed

  logic [7:0]          w_step_byte;
  logic [31:0]         w_crc_next;
  logic [10:0]         w_count_inc;

  // Pad bytes (and the pad byte issued on the falling strobe) feed zeros
  always_comb begin
    w_step_byte = idata;
    if (r_state == ST_PAD || !istrobe) begin
      w_step_byte = 8'h00;
    end
  end

  // Covered byte counter saturates instead of wrapping
  always_comb begin
    w_count_inc = (r_count == c_CNT_MAX) ? r_count : r_count + 11'd1;
  end

  crc32_byte_step u_crc_step (
    .crc_in  (r_crc),
    .byte_in (w_step_byte),
    .crc_out (w_crc_next)
  );

  // Frame sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      odata      <= 8'h00;
      ostrobe    <= 1'b0;
      ofcs       <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      r_state    <= ST_IDLE;
      r_crc      <= CRC_INIT;
      r_count    <= 11'd0;
      r_skip_cnt <= '0;
      r_fcs_idx  <= 2'd0;
      r_viol     <= 1'b0;
      r_started  <= 1'b0;
    end else begin
      odata     <= 8'h00;
      ostrobe   <= 1'b0;
      ofcs      <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_started <= 1'b1;
          if (istrobe) begin
            if (!r_started) begin
              // Strobe already high when reset released: never emit a partial frame
              r_state <= ST_DRAIN;
            end else begin
              odata     <= idata;
              ostrobe   <= 1'b1;
              busy      <= 1'b1;
              r_viol    <= 1'b0;
              r_fcs_idx <= 2'd0;
              if (PRE_SKIP == 0) begin
                r_crc   <= w_crc_next;
                r_count <= 11'd1;
                r_state <= ST_DATA;
              end else if (PRE_SKIP == 1) begin
                r_count <= 11'd0;
                r_state <= ST_DATA;
              end else begin
                r_count    <= 11'd0;
                r_skip_cnt <= c_SKIP_ONE;
                r_state    <= ST_SKIP;
              end
            end
          end
        end

        ST_SKIP: begin
          if (istrobe) begin
            odata      <= idata;
            ostrobe    <= 1'b1;
            busy       <= 1'b1;
            r_skip_cnt <= r_skip_cnt + c_SKIP_ONE;
            if (r_skip_cnt == c_SKIP_LAST) begin
              r_state <= ST_DATA;
            end
          end else begin
            // Frame ended inside the preamble: drop it, no FCS
            frame_err <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        ST_DATA: begin
          ostrobe <= 1'b1;
          busy    <= 1'b1;
          if (istrobe) begin
            odata   <= idata;
            r_crc   <= w_crc_next;
            r_count <= w_count_inc;
          end else begin
`ifdef ETH_MIN_PAD_EN
            if (r_count < c_MIN_LEN) begin
              // First pad byte goes out in the slot the FCS would otherwise take
              r_crc   <= w_crc_next;
              r_count <= w_count_inc;
              r_state <= ST_PAD;
            end else begin
              odata     <= fcs_byte(r_crc, 2'd0);
              ofcs      <= 1'b1;
              r_fcs_idx <= 2'd1;
              r_state   <= ST_FCS;
            end
`else
            odata     <= fcs_byte(r_crc, 2'd0);
            ofcs      <= 1'b1;
            r_fcs_idx <= 2'd1;
            r_state   <= ST_FCS;
`endif
          end
        end

`ifdef ETH_MIN_PAD_EN
        ST_PAD: begin
          ostrobe <= 1'b1;
          busy    <= 1'b1;
          if (istrobe && !r_viol) begin
            frame_err <= 1'b1;
            r_viol    <= 1'b1;
          end
          if (r_count < c_MIN_LEN) begin
            r_crc   <= w_crc_next;
            r_count <= w_count_inc;
          end else begin
            odata     <= fcs_byte(r_crc, 2'd0);
            ofcs      <= 1'b1;
            r_fcs_idx <= 2'd1;
            r_state   <= ST_FCS;
          end
        end
`endif

        ST_FCS: begin
          odata   <= fcs_byte(r_crc, r_fcs_idx);
          ofcs    <= 1'b1;
          ostrobe <= 1'b1;
          busy    <= 1'b1;
          if (istrobe && !r_viol) begin
            frame_err <= 1'b1;
            r_viol    <= 1'b1;
          end
          if (r_fcs_idx == 2'd3) begin
            // Reseed now so a frame starting next cycle sees a clean CRC
            r_crc     <= CRC_INIT;
            r_count   <= 11'd0;
            r_fcs_idx <= 2'd0;
            r_state   <= istrobe ? ST_DRAIN : ST_IDLE;
          end else begin
            r_fcs_idx <= r_fcs_idx + 2'd1;
          end
        end

        ST_DRAIN: begin
          r_crc   <= CRC_INIT;
          r_count <= 11'd0;
          if (!istrobe) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_crc   <= CRC_INIT;
          r_count <= 11'd0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : eth_fcs_append
`default_nettype wire

// File: tb/tb_eth_fcs_append.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_fcs_append
// Description : Directed self-checking bench for eth_fcs_append with one
//               instance at PRE_SKIP=0 and one at PRE_SKIP=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_fcs_append;

`ifdef ETH_MIN_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int PADGAP = PAD ? 60 : 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] idata0, idata8, odata0, odata8;
  logic       istrobe0, istrobe8, ostrobe0, ostrobe8;
  logic       ofcs0, ofcs8, busy0, busy8, ferr0, ferr8;

  eth_fcs_append #(.PRE_SKIP(0), .MIN_LEN(60)) dut0 (
    .clk(clk), .rst_n(rst_n), .idata(idata0), .istrobe(istrobe0),
    .odata(odata0), .ostrobe(ostrobe0), .ofcs(ofcs0), .busy(busy0),
    .frame_err(ferr0)
  );

  eth_fcs_append #(.PRE_SKIP(8), .MIN_LEN(60)) dut8 (
    .clk(clk), .rst_n(rst_n), .idata(idata8), .istrobe(istrobe8),
    .odata(odata8), .ostrobe(ostrobe8), .ofcs(ofcs8), .busy(busy8),
    .frame_err(ferr8)
  );

  int         n_pass = 0;
  int         n_total = 0;
  int         sel = 0;
  int         tick_no = 0;
  int         start_tick = 0;
  int         first_out = -1;
  int         zero_bad = 0, busy_bad = 0, err_cnt = 0, rises = 0;
  logic       prev_os = 1'b0;
  logic [7:0] q[$];
  logic       qf[$];
  logic [7:0] tx[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic int exp_len(input int pre, input int cov);
    int c2;
    c2 = (PAD && cov < 60) ? 60 : cov;
    return pre + c2 + 4;
  endfunction

  function automatic logic [7:0] qb(input int i);
    if (i < q.size()) return q[i];
    return 8'hxx;
  endfunction

  function automatic logic qfl(input int i);
    if (i < qf.size()) return qf[i];
    return 1'bx;
  endfunction

  function automatic int fcs_flags();
    int n = 0;
    foreach (qf[i]) if (qf[i]) n++;
    return n;
  endfunction

  task automatic clear_rec();
    q.delete(); qf.delete();
    first_out = -1; zero_bad = 0; busy_bad = 0; err_cnt = 0; rises = 0;
    prev_os = 1'b0;
  endtask

  task automatic sample();
    logic [7:0] od;
    logic os, of, ob, oe;
    if (sel == 0) begin od = odata0; os = ostrobe0; of = ofcs0; ob = busy0; oe = ferr0; end
    else          begin od = odata8; os = ostrobe8; of = ofcs8; ob = busy8; oe = ferr8; end
    tick_no++;
    if (os === 1'b1) begin
      q.push_back(od); qf.push_back(of);
      if (first_out < 0) first_out = tick_no;
      if (!prev_os) rises++;
    end else if (od !== 8'h00 || of !== 1'b0) zero_bad++;
    if (ob !== os) busy_bad++;
    if (oe === 1'b1) err_cnt++;
    prev_os = (os === 1'b1);
  endtask

  task automatic tick(input logic s, input logic [7:0] d);
    @(negedge clk);
    sample();
    if (sel == 0) begin istrobe0 = s; idata0 = d; istrobe8 = 1'b0; idata8 = 8'h00; end
    else          begin istrobe8 = s; idata8 = d; istrobe0 = 1'b0; idata0 = 8'h00; end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00);
  endtask

  task automatic send_tx(input int toff, input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, tx[toff+i]);
      if (i == 0) start_tick = tick_no;
    end
  endtask

  // Passthrough, zero pad, ofcs placement and receive-side residue of one frame
  task automatic check_frame(input string tag, input int pre, input int cov,
                             input int qoff, input int toff);
    int len, bad, badf;
    logic [31:0] c;
    logic [7:0]  b;
    len = exp_len(pre, cov); bad = 0; badf = 0; c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      b = qb(qoff + i);
      if (qfl(qoff + i) !== (i >= len - 4)) badf++;
      if (i < pre + cov) begin
        if (b !== tx[toff + i]) bad++;
      end else if (i < len - 4) begin
        if (b !== 8'h00) bad++;
      end
      if (i >= pre) c = crc_upd(c, b);
    end
    check({tag, "_data"}, bad, 0);
    check({tag, "_ofcs"}, badf, 0);
    check({tag, "_residue"}, c, 32'hDEBB20E3);
  endtask

  initial begin
    rst_n = 1'b0;
    idata0 = 8'h00; idata8 = 8'h00; istrobe0 = 1'b0; istrobe8 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_odata",   {24'h0, odata0}, 32'h0);
    check("rst_ostrobe", {31'h0, ostrobe0}, 32'h0);
    check("rst_ofcs",    {31'h0, ofcs0}, 32'h0);
    check("rst_busy",    {31'h0, busy0}, 32'h0);
    check("rst_ferr",    {31'h0, ferr0}, 32'h0);
    check("rst_ostrobe8",{31'h0, ostrobe8}, 32'h0);
    rst_n = 1'b1;
    idle(3);

    // "123456789", no preamble
    sel = 0; clear_rec(); tx.delete();
    for (int i = 0; i < 9; i++) tx.push_back(8'h31 + 8'(i));
    send_tx(0, 9); idle(8 + PADGAP);
    check("t1_len", q.size(), exp_len(0, 9));
    check("t1_latency", first_out, start_tick + 1);
    check_frame("t1", 0, 9, 0, 0);
`ifndef ETH_MIN_PAD_EN
    check("t1_fcs", {qb(9), qb(10), qb(11), qb(12)}, 32'h2639F4CB);
`endif
    check("t1_nfcs", fcs_flags(), 4);
    check("t1_rises", rises, 1);
    check("t1_err", err_cnt, 0);
    check("t1_busy", busy_bad, 0);
    check("t1_idle_zero", zero_bad, 0);

    // Preamble + SFD then "123456789"
    sel = 8; idle(2); clear_rec(); tx.delete();
    for (int i = 0; i < 7; i++) tx.push_back(8'h55);
    tx.push_back(8'hD5);
    for (int i = 0; i < 9; i++) tx.push_back(8'h31 + 8'(i));
    send_tx(0, 17); idle(8 + PADGAP);
    check("t2_len", q.size(), exp_len(8, 9));
    check_frame("t2", 8, 9, 0, 0);
`ifndef ETH_MIN_PAD_EN
    check("t2_fcs", {qb(17), qb(18), qb(19), qb(20)}, 32'h2639F4CB);
`endif
    check("t2_busy", busy_bad, 0);
    check("t2_err", err_cnt, 0);

    // Preamble only: empty covered message
    clear_rec(); tx.delete();
    for (int i = 0; i < 7; i++) tx.push_back(8'h55);
    tx.push_back(8'hD5);
    send_tx(0, 8); idle(8 + PADGAP);
    check("t3_len", q.size(), exp_len(8, 0));
    check_frame("t3", 8, 0, 0, 0);
`ifndef ETH_MIN_PAD_EN
    check("t3_fcs", {qb(8), qb(9), qb(10), qb(11)}, 32'h00000000);
`endif
    check("t3_err", err_cnt, 0);

    // Frame ends inside the preamble
    clear_rec(); tx.delete();
    for (int i = 0; i < 5; i++) tx.push_back(8'h55);
    send_tx(0, 5); idle(10);
    check("t4_err", err_cnt, 1);
    check("t4_len", q.size(), 5);
    check("t4_nfcs", fcs_flags(), 0);

    // Back-to-back 20-byte frames, minimum gap
    sel = 0; idle(2); clear_rec(); tx.delete();
    for (int i = 0; i < 20; i++) tx.push_back(8'(i * 13 + 1));
    for (int i = 0; i < 20; i++) tx.push_back(8'(i * 29 + 7));
    send_tx(0, 20); idle(4 + (PAD ? 40 : 0));
    send_tx(20, 20); idle(8 + PADGAP);
    check("t5_len", q.size(), 2 * exp_len(0, 20));
    check_frame("t5a", 0, 20, 0, 0);
    check_frame("t5b", 0, 20, exp_len(0, 20), 20);
    check("t5_err", err_cnt, 0);
    check("t5_busy", busy_bad, 0);

    // Strobe reasserted one cycle after frame end
    clear_rec(); tx.delete();
    for (int i = 0; i < 10; i++) tx.push_back(8'hC0 + 8'(i));
    send_tx(0, 10); idle(1);
    for (int i = 0; i < 6; i++) tick(1'b1, 8'hA0 + 8'(i));
    idle(12 + PADGAP);
    check("t6_err", err_cnt, 1);
    check("t6_len", q.size(), exp_len(0, 10));
    check_frame("t6", 0, 10, 0, 0);

    // Reset mid-frame with strobe held high
    clear_rec(); tx.delete();
    for (int i = 0; i < 5; i++) tx.push_back(8'h40 + 8'(i));
    send_tx(0, 5);
    @(negedge clk); sample();
    rst_n = 1'b0; istrobe0 = 1'b1; idata0 = 8'h77;
    #1;
    check("t7_rst_ostrobe", {31'h0, ostrobe0}, 32'h0);
    check("t7_rst_odata", {24'h0, odata0}, 32'h0);
    check("t7_rst_busy", {31'h0, busy0}, 32'h0);
    clear_rec();
    tick(1'b1, 8'h77);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b1, 8'h78 + 8'(i));
    idle(5);
    check("t7_drain_len", q.size(), 0);
    clear_rec(); tx.delete();
    for (int i = 0; i < 9; i++) tx.push_back(8'h31 + 8'(i));
    send_tx(0, 9); idle(8 + PADGAP);
    check("t7_len", q.size(), exp_len(0, 9));
    check_frame("t7", 0, 9, 0, 0);
`ifndef ETH_MIN_PAD_EN
    check("t7_fcs", {qb(9), qb(10), qb(11), qb(12)}, 32'h2639F4CB);
`endif
    check("t7_err", err_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_eth_fcs_append
`default_nettype wire
